data_island_scheduler: RTL

//  Per-pixel period sequencer for the HDMI TMDS link. From the raster position (cx, cy) it chooses,

---
 rtl/hdmi_period_pkg.sv | 17 +
 rtl/data_island_scheduler.sv | 105 ++++++++++
 2 files changed

// File: rtl/hdmi_period_pkg.sv
// hdmi_period_pkg: period codes, island FSM states and HDMI period lengths
package hdmi_period_pkg;
  typedef enum logic [2:0] {
    CTRL           = 3'd0,
    VIDEO_PREAMBLE = 3'd1,
    VIDEO_GUARD    = 3'd2,
    VIDEO          = 3'd3,
    DI_PREAMBLE    = 3'd4,
    DI_GUARD       = 3'd5,
    DATA_ISLAND    = 3'd6
  } mode_t;
  typedef enum logic [2:0] {IDLE, DI_PRE, DI_LEAD, DI_PKT, DI_TRAIL} di_state_t;
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN = 2;
  localparam int PACKET_LEN = 32;
  localparam int MAX_PACKETS_HDMI = 18;
endpackage

// File: rtl/data_island_scheduler.sv
// data_island_scheduler: per-pixel TMDS period sequencer placing one data island per horizontal blank
module data_island_scheduler
  import hdmi_period_pkg::*;
#(
  parameter int FRAME_WIDTH = 1650,
  parameter int FRAME_HEIGHT = 750,
  parameter int SCREEN_WIDTH = 1280,
  parameter int SCREEN_HEIGHT = 720,
  parameter int DI_START_GAP = 4,
  parameter int MAX_PACKETS = MAX_PACKETS_HDMI
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [10:0] cx,
  input  logic [9:0]  cy,
  output logic [2:0]  mode,
  output logic        packet_enable,
  output logic [4:0]  packet_pixel_counter,
  output logic        video_field_end
);
  // 26 = preamble + both guards + minimum tail before the next line
  localparam int N_RAW = (FRAME_WIDTH - SCREEN_WIDTH - DI_START_GAP - 26) / PACKET_LEN;
  localparam int N = N_RAW > MAX_PACKETS ? MAX_PACKETS : N_RAW;
  localparam logic [10:0] START_X = 11'(SCREEN_WIDTH + DI_START_GAP - 1);
  localparam logic [10:0] SW_X = 11'(SCREEN_WIDTH);
  localparam logic [10:0] VP_LO = 11'(FRAME_WIDTH - 10);
  localparam logic [10:0] VP_HI = 11'(FRAME_WIDTH - 3);
  localparam logic [10:0] VG_LO = 11'(FRAME_WIDTH - 2);
  localparam logic [10:0] FW1_X = 11'(FRAME_WIDTH - 1);
  localparam logic [9:0] SH_Y = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] SH1_Y = 10'(SCREEN_HEIGHT - 1);
  localparam logic [9:0] FH_Y = 10'(FRAME_HEIGHT);
  localparam logic [9:0] FH1_Y = 10'(FRAME_HEIGHT - 1);
  localparam logic [4:0] PRE_END = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] GRD_END = 5'(GUARD_LEN - 1);
  localparam logic [4:0] PIX_END = 5'(PACKET_LEN - 1);
  localparam logic [4:0] LAST_PKT = 5'(N > 0 ? N - 1 : 0);
  di_state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d, pkt_q, pkt_d, ppc_q, ppc_d;
  mode_t mode_q, mode_d;
  logic pe_q, pe_d, vfe_q, vfe_d;
  logic video, next_active;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 5'd1;
    pkt_d = pkt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pkt_d = '0;
        if (cx == START_X && cy < FH_Y && enable && N > 0) state_d = DI_PRE;
      end
      DI_PRE: if (cnt_q == PRE_END) begin
        state_d = DI_LEAD;
        cnt_d = '0;
      end
      DI_LEAD: if (cnt_q == GRD_END) begin
        state_d = DI_PKT;
        cnt_d = '0;
      end
      DI_PKT: if (cnt_q == PIX_END) begin
        state_d = pkt_q == LAST_PKT ? DI_TRAIL : DI_PKT;
        pkt_d = pkt_q + 5'd1;
      end
      DI_TRAIL: if (cnt_q == GRD_END) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    video = cx < SW_X && cy < SH_Y;
    next_active = cy < SH1_Y || cy == FH1_Y;
    mode_d = video ? VIDEO :
             state_q == DI_PRE ? DI_PREAMBLE :
             state_q == DI_LEAD || state_q == DI_TRAIL ? DI_GUARD :
             state_q == DI_PKT ? DATA_ISLAND :
             next_active && cx >= VP_LO && cx <= VP_HI ? VIDEO_PREAMBLE :
             next_active && cx >= VG_LO && cx <= FW1_X ? VIDEO_GUARD : CTRL;
    pe_d = (state_q == DI_LEAD && cnt_q == GRD_END) ||
           (state_q == DI_PKT && cnt_q == PIX_END && pkt_q != LAST_PKT);
    ppc_d = state_q == DI_PKT ? cnt_q : 5'd0;
    vfe_d = cx == FW1_X && cy == FH1_Y;
  end
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pkt_q <= '0;
      mode_q <= CTRL;
      pe_q <= 1'b0;
      ppc_q <= '0;
      vfe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pkt_q <= pkt_d;
      mode_q <= mode_d;
      pe_q <= pe_d;
      ppc_q <= ppc_d;
      vfe_q <= vfe_d;
    end
  end
  assign mode = mode_q;
  assign packet_enable = pe_q;
  assign packet_pixel_counter = ppc_q;
  assign video_field_end = vfe_q;
endmodule
